// File: rtl/dlfloat_mac_host.sv
// rtl/dlfloat_mac_host.sv - host link controller for the byte-serial DLFloat16 MAC tile
// Serialises operand pairs onto the tile bus and reassembles byte-serial results.
module dlfloat_mac_host #(
    parameter int RES_LAT = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        op_valid,
    output logic        op_ready,
    input  logic [15:0] op_a,
    input  logic [15:0] op_b,
    output logic [15:0] bus_out,
    input  logic [7:0]  byte_in,
    output logic        res_valid,
    output logic [15:0] res_data,
    output logic        res_inf,
    output logic        busy
);

    logic             phase;
    logic             b_loaded;
    logic [15:0]      b_hold;
    logic [15:0]      lo_hold;
    logic [RES_LAT:0] track;
    logic             hi_pend;
    logic             accept;
    logic [15:0]      assembled;

    assign op_ready  = phase;
    assign accept    = op_valid & op_ready;
    assign busy      = b_loaded | (|track);
    assign assembled = {byte_in, lo_hold};

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            phase     <= 1'b0;
            b_loaded  <= 1'b0;
            b_hold    <= 16'h0000;
            lo_hold   <= 16'h0000;
            track     <= '0;
            hi_pend   <= 1'b0;
            bus_out   <= 16'h0000;
            res_valid <= 1'b0;
            res_data  <= 16'h0000;
            res_inf   <= 1'b0;
        end else begin
            phase <= ~phase;

            // Marker enters on the phase-0 edge, so it is in bit 0 while B is on the bus.
            track   <= {track[RES_LAT-1:0], ~phase & b_loaded};
            hi_pend <= track[RES_LAT];

            if (track[RES_LAT]) begin
                lo_hold <= {8'h00, byte_in};
            end

            res_valid <= hi_pend;
            if (hi_pend) begin
                res_data <= {byte_in, lo_hold[7:0]};
                if ({byte_in, lo_hold[7:0]} == 16'hFFFF) begin
                    res_inf <= 1'b1;
                end
            end

            if (phase) begin
                if (accept) begin
                    bus_out  <= op_a;
                    b_hold   <= op_b;
                    b_loaded <= 1'b1;
                end else begin
                    bus_out <= 16'h0000;
                end
            end else begin
                bus_out  <= b_loaded ? b_hold : 16'h0000;
                b_loaded <= 1'b0;
            end
        end
    end

    // Upper half of lo_hold is always zero; only the low byte is ever stored.
    logic unused_ok;
    assign unused_ok = ^{assembled[15:8], lo_hold[15:8]};

endmodule
